// File: rtl/coin_acceptor_multi_if.sv
// Coin acceptor bus: coin/cancel keys in, credit/vend/reject/refund out.
// master drives the keys; slave is the acceptor.
interface coin_acceptor_multi_if #(
    parameter int NUM_COINS = 2,
    parameter int CREDIT_W  = 8,
    parameter int COUNT_W   = 8
);
    logic [NUM_COINS-1:0] key;
    logic                 key_cancel;
    logic [COUNT_W-1:0]   leds;
    logic [CREDIT_W-1:0]  credit;
    logic                 vend;
    logic                 reject;
    logic                 refund_valid;
    logic [CREDIT_W-1:0]  refund_amt;

    modport master (
        output key, key_cancel,
        input  leds, credit, vend, reject,
        input  refund_valid, refund_amt
    );

    modport slave (
        input  key, key_cancel,
        output leds, credit, vend, reject,
        output refund_valid, refund_amt
    );
endinterface

// File: rtl/coin_acceptor_multi.sv
// Multi-coin credit accumulator / vender with vend counter and reject.
// Ports: clk, rst (async high), bus (slave): key[], key_cancel in;
// leds, credit, vend, reject, refund_valid, refund_amt out.
// Optional macro REFUND_EN enables the cancel/refund path.
module coin_acceptor_multi #(
    parameter int NUM_COINS = 2,
    parameter int COIN0_VAL = 5,
    parameter int COIN1_VAL = 10,
    parameter int COIN2_VAL = 25,
    parameter int COIN3_VAL = 50,
    parameter int PRICE     = 20,
    parameter int CREDIT_W  = 8,
    parameter int COUNT_W   = 8
) (
    input logic                   clk,
    input logic                   rst,
    coin_acceptor_multi_if.slave  bus
);

    typedef enum logic {IDLE, HELD} state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [3:0][CREDIT_W-1:0] VALS = {
        CREDIT_W'(COIN3_VAL), CREDIT_W'(COIN2_VAL),
        CREDIT_W'(COIN1_VAL), CREDIT_W'(COIN0_VAL)
    };

    state_t state_q, state_d;

    logic [NUM_COINS-1:0] ks1, ks2, p;
    logic                 pc;

    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [COUNT_W-1:0]  leds_q, leds_d;
    logic                vend_q, vend_d;
    logic                reject_q, reject_d;

    logic [CREDIT_W-1:0] coin_v;
    logic [CREDIT_W:0]   sum;
    logic [2:0]          npress;
    logic                can_vend, one_coin, multi;

    // released keys are high, so the synchroniser resets to all ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ks1 <= '1;
            ks2 <= '1;
        end else begin
            ks1 <= bus.key;
            ks2 <= ks1;
        end
    end

    assign p = ~ks2;

`ifdef REFUND_EN
    logic cs1, cs2;
    logic cancel_only;
    logic                rv_q, rv_d;
    logic [CREDIT_W-1:0] ramt_q, ramt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs1 <= 1'b1;
            cs2 <= 1'b1;
        end else begin
            cs1 <= bus.key_cancel;
            cs2 <= cs1;
        end
    end

    assign pc          = ~cs2;
    assign cancel_only = pc && (p == '0);
`else
    assign pc = 1'b0;
`endif

    always_comb begin
        npress = {2'b00, pc};
        coin_v = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            npress = npress + {2'b00, p[i]};
            if (p[i]) coin_v = coin_v | VALS[i];
        end
    end

    // overflow shows up in the extra top bit
    assign sum      = {1'b0, credit_q} + {1'b0, coin_v};
    assign can_vend = credit_q >= PRICE_C;
    assign one_coin = (npress == 3'd1) && !pc;
    assign multi    = npress >= 3'd2;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        leds_d   = leds_q;
        vend_d   = 1'b0;
        reject_d = 1'b0;
`ifdef REFUND_EN
        rv_d     = 1'b0;
        ramt_d   = ramt_q;
`endif
        unique case (state_q)
            IDLE: begin
                unique case (1'b1)
                    can_vend: begin
                        credit_d = credit_q - PRICE_C;
                        leds_d   = leds_q + COUNT_W'(1);
                        vend_d   = 1'b1;
                    end
                    one_coin: begin
                        if (!sum[CREDIT_W]) credit_d = sum[CREDIT_W-1:0];
                        else reject_d = 1'b1;
                        state_d = HELD;
                    end
                    multi: begin
                        reject_d = 1'b1;
                        state_d  = HELD;
                    end
`ifdef REFUND_EN
                    cancel_only: begin
                        ramt_d   = credit_q;
                        rv_d     = 1'b1;
                        credit_d = '0;
                        state_d  = HELD;
                    end
`endif
                    default: ;
                endcase
            end
            HELD: begin
                if (p == '0 && !pc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            credit_q <= '0;
            leds_q   <= '0;
            vend_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            leds_q   <= leds_d;
            vend_q   <= vend_d;
            reject_q <= reject_d;
        end
    end

`ifdef REFUND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rv_q   <= 1'b0;
            ramt_q <= '0;
        end else begin
            rv_q   <= rv_d;
            ramt_q <= ramt_d;
        end
    end

    assign bus.refund_valid = rv_q;
    assign bus.refund_amt   = ramt_q;
`else
    assign bus.refund_valid = 1'b0;
    assign bus.refund_amt   = '0;
`endif

    assign bus.credit = credit_q;
    assign bus.leds   = leds_q;
    assign bus.vend   = vend_q;
    assign bus.reject = reject_q;

endmodule
